// File: rtl/el2_trace_buf_pkg.sv
// Types shared by the trace retirement buffer: core packet, filter mode,
// stored entry layout, gap state and the packet <-> entry conversions.
package el2_trace_buf_pkg;

   typedef struct packed {
      logic        trace_rv_i_valid_ip;
      logic [31:0] trace_rv_i_insn_ip;
      logic [31:0] trace_rv_i_address_ip;
      logic        trace_rv_i_exception_ip;
      logic [4:0]  trace_rv_i_ecause_ip;
      logic        trace_rv_i_interrupt_ip;
      logic [31:0] trace_rv_i_tval_ip;
   } el2_trace_pkt_t;

   // 2'b11 is not named; the filter treats it as OFF.
   typedef enum logic [1:0] {
      TRACE_ALL = 2'b00,
      TRACE_EXC = 2'b01,
      TRACE_OFF = 2'b10
   } el2_trace_mode_e;

   // Valid bit is implied by occupancy, so it is not stored.
   typedef struct packed {
      logic        gap;
      logic [31:0] insn;
      logic [31:0] addr;
      logic        exc;
      logic [4:0]  ecause;
      logic        intr;
      logic [31:0] tval;
   } el2_trace_buf_entry_t;

   typedef enum logic {
      GAP_NORMAL  = 1'b0,
      GAP_PENDING = 1'b1
   } el2_trace_gap_e;

   localparam int TRACE_ENTRY_W = $bits(el2_trace_buf_entry_t);

   function automatic el2_trace_buf_entry_t pkt_to_entry(el2_trace_pkt_t p, logic gap);
      el2_trace_buf_entry_t e;
      e.gap    = gap;
      e.insn   = p.trace_rv_i_insn_ip;
      e.addr   = p.trace_rv_i_address_ip;
      e.exc    = p.trace_rv_i_exception_ip;
      e.ecause = p.trace_rv_i_ecause_ip;
      e.intr   = p.trace_rv_i_interrupt_ip;
      e.tval   = p.trace_rv_i_tval_ip;
      return e;
   endfunction

   function automatic el2_trace_pkt_t entry_to_pkt(el2_trace_buf_entry_t e);
      el2_trace_pkt_t p;
      p.trace_rv_i_valid_ip     = 1'b1;
      p.trace_rv_i_insn_ip      = e.insn;
      p.trace_rv_i_address_ip   = e.addr;
      p.trace_rv_i_exception_ip = e.exc;
      p.trace_rv_i_ecause_ip    = e.ecause;
      p.trace_rv_i_interrupt_ip = e.intr;
      p.trace_rv_i_tval_ip      = e.tval;
      return p;
   endfunction

endpackage

// File: rtl/el2_trace_buf_ram.sv
// DEPTH-entry flop array, one write port, one asynchronous read port.
// Data is not reset; occupancy in the top decides what is meaningful.
module el2_trace_buf_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 104,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   // Write the addressed entry when enabled
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/el2_trace_buf.sv
// Trace retirement buffer: mode filter, lossy FIFO with gap marking,
// saturating drop counter and a valid/ready output stream. Never stalls the core.
module el2_trace_buf
   import el2_trace_buf_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  el2_trace_pkt_t  i_trace_in,
   input  el2_trace_mode_e i_mode,
   input  logic            i_clear,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output el2_trace_pkt_t  o_out_pkt,
   output logic            o_out_gap,
   output logic [LW-1:0]   o_level,
   output logic [CNT_W-1:0] o_drop_cnt,
   output logic            o_overflow
);

   localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic [CNT_W-1:0]     r_drop_cnt;
   logic                 r_overflow;
   el2_trace_gap_e       r_gap_st;

   logic                 w_qual, w_full, w_empty, w_pop, w_push, w_drop;
   el2_trace_buf_entry_t w_wr_entry, w_rd_entry;
   logic [TRACE_ENTRY_W-1:0] w_rd_raw;

   // Filter: OFF and the unnamed encoding both reject everything
   always_comb begin
      w_qual = 1'b0;
      if (i_trace_in.trace_rv_i_valid_ip) begin
         case (i_mode)
            TRACE_ALL: w_qual = 1'b1;
            TRACE_EXC: w_qual = i_trace_in.trace_rv_i_exception_ip |
                                i_trace_in.trace_rv_i_interrupt_ip;
            default:   w_qual = 1'b0;
         endcase
      end
   end

   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);
   assign w_pop   = ~w_empty & i_out_ready;
   // A pop in the same cycle frees the slot, so full never drops then
   assign w_push  = w_qual & (~w_full | w_pop);
   assign w_drop  = w_qual & w_full & ~w_pop;

   assign w_wr_entry = pkt_to_entry(i_trace_in, r_gap_st == GAP_PENDING);

   el2_trace_buf_ram #(
      .DEPTH (DEPTH),
      .W     (TRACE_ENTRY_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_raw)
   );

   assign w_rd_entry = el2_trace_buf_entry_t'(w_rd_raw);

   // Pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Gap FSM: a drop arms it, the next stored packet carries the mark
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gap_st <= GAP_NORMAL;
      end else begin
         case (r_gap_st)
            GAP_NORMAL:  if (w_drop) r_gap_st <= GAP_PENDING;
            GAP_PENDING: if (w_push) r_gap_st <= GAP_NORMAL;
            default:     r_gap_st <= GAP_NORMAL;
         endcase
      end
   end

   // Drop accounting; clear takes priority over a coincident drop
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end
   end

   // Output mux: head packet only while valid, zero otherwise
   always_comb begin
      o_out_pkt = '0;
      o_out_gap = 1'b0;
      if (!w_empty) begin
         o_out_pkt = entry_to_pkt(w_rd_entry);
         o_out_gap = w_rd_entry.gap;
      end
   end

   assign o_out_valid = ~w_empty;
   assign o_level     = r_level;
   assign o_drop_cnt  = r_drop_cnt;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_el2_trace_buf.sv
// Directed bench for el2_trace_buf: a negedge scoreboard checks every popped
// packet and its gap flag; directed steps check occupancy and counters.
module tb_el2_trace_buf;
   import el2_trace_buf_pkg::*;

   localparam int DEPTH = 8;

   logic            clk, rst, clr, rdy;
   el2_trace_pkt_t  tin;
   el2_trace_mode_e mode;

   logic            a_valid, b_valid, a_gap, b_gap, a_ovf, b_ovf;
   el2_trace_pkt_t  a_pkt, b_pkt;
   logic [3:0]      a_level, b_level;
   logic [15:0]     a_cnt;
   logic [3:0]      b_cnt;

   el2_trace_buf #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_trace_in(tin), .i_mode(mode), .i_clear(clr),
      .o_out_valid(a_valid), .i_out_ready(rdy), .o_out_pkt(a_pkt), .o_out_gap(a_gap),
      .o_level(a_level), .o_drop_cnt(a_cnt), .o_overflow(a_ovf));

   el2_trace_buf #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_trace_in(tin), .i_mode(mode), .i_clear(clr),
      .o_out_valid(b_valid), .i_out_ready(rdy), .o_out_pkt(b_pkt), .o_out_gap(b_gap),
      .o_level(b_level), .o_drop_cnt(b_cnt), .o_overflow(b_ovf));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      el2_trace_pkt_t pkt;
      logic           gap;
   } sb_t;

   sb_t sbq[$];
   int  m_level = 0;
   logic m_gap  = 1'b0;

   // Scoreboard: pop/compare what leaves, push what should enter
   always @(negedge clk) begin
      logic q, p;
      sb_t  e;
      if (rst) begin
         sbq.delete();
         m_level = 0;
         m_gap   = 1'b0;
      end else begin
         chk("valid_vs_model", a_valid, m_level > 0);
         chk("level_vs_model", a_level, m_level);
         q = tin.trace_rv_i_valid_ip &&
             (mode == TRACE_ALL ||
              (mode == TRACE_EXC && (tin.trace_rv_i_exception_ip || tin.trace_rv_i_interrupt_ip)));
         p = (m_level > 0) && rdy;
         if (p) begin
            e = sbq.pop_front();
            chk("out_pkt", a_pkt, e.pkt);
            chk("out_gap", a_gap, e.gap);
            n_pop++;
         end
         if (q && (m_level < DEPTH || p)) begin
            e.pkt = tin;
            e.gap = m_gap;
            sbq.push_back(e);
            m_gap = 1'b0;
         end else if (q) begin
            m_gap = 1'b1;
         end
         m_level = sbq.size();
      end
   end

   function automatic el2_trace_pkt_t mkpkt(logic [31:0] addr, logic exc, logic [4:0] ec, logic intr);
      el2_trace_pkt_t p;
      p.trace_rv_i_valid_ip     = 1'b1;
      p.trace_rv_i_insn_ip      = addr ^ 32'hDEAD_0000;
      p.trace_rv_i_address_ip   = addr;
      p.trace_rv_i_exception_ip = exc;
      p.trace_rv_i_ecause_ip    = ec;
      p.trace_rv_i_interrupt_ip = intr;
      p.trace_rv_i_tval_ip      = ~addr;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] addr);
      tin = mkpkt(addr, 1'b0, 5'd0, 1'b0);
      tick();
      tin = '0;
   endtask

   task automatic idle(input int n);
      tin = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int pops0;
      rst = 1'b1; clr = 1'b0; rdy = 1'b0; tin = '0; mode = TRACE_ALL;
      tick(); tick();
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_level", a_level, 4'd0);
      chk("rst_cnt", a_cnt, 16'd0);
      chk("rst_ovf", a_ovf, 1'b0);
      chk("rst_pkt", a_pkt, '0);
      chk("rst_gap", a_gap, 1'b0);
      rst = 1'b0;
      tick();

      // 1: streaming in order, one-cycle latency, level never exceeds 1
      rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tin = mkpkt(32'h100 + 32'(4 * k), 1'b0, 5'd0, 1'b0);
         tick();
         chk("t1_valid", a_valid, 1'b1);
         chk("t1_level", a_level, 4'd1);
         chk("t1_addr", a_pkt.trace_rv_i_address_ip, 32'h100 + 32'(4 * k));
         chk("t1_gap", a_gap, 1'b0);
      end
      idle(1);
      chk("t1_empty", a_level, 4'd0);

      // 2: fill with ready low, two drops
      rdy = 1'b0;
      for (int k = 0; k < 10; k++) send(32'h200 + 32'(4 * k));
      chk("t2_level", a_level, 4'd8);
      chk("t2_cnt", a_cnt, 16'd2);
      chk("t2_ovf", a_ovf, 1'b1);
      chk("t2_head_gap", a_gap, 1'b0);
      // 3: full, pop and qualifying push together: accepted, no drop
      rdy = 1'b1;
      send(32'h300);
      chk("t3_level", a_level, 4'd8);
      chk("t3_cnt", a_cnt, 16'd2);
      idle(10);
      chk("t2_drained", a_level, 4'd0);

      // 4: exception filter, then OFF encodings
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_cnt", a_cnt, 16'd0);
      chk("clr_ovf", a_ovf, 1'b0);
      mode  = TRACE_EXC;
      pops0 = n_pop;
      tin = mkpkt(32'h400, 1'b0, 5'd0, 1'b0); tick();
      tin = mkpkt(32'h404, 1'b1, 5'd2, 1'b0); tick();
      tin = mkpkt(32'h408, 1'b0, 5'd7, 1'b1); tick();
      tin = mkpkt(32'h40C, 1'b0, 5'd0, 1'b0); tick();
      idle(3);
      chk("t4_exc_pops", n_pop - pops0, 2);
      rdy  = 1'b0;
      mode = TRACE_OFF;
      send(32'h500); send(32'h504);
      mode = el2_trace_mode_e'(2'b11);
      send(32'h508); send(32'h50C);
      chk("t4_off_level", a_level, 4'd0);
      chk("t4_off_cnt", a_cnt, 16'd0);

      // 5: saturation on the narrow counter, clear racing a drop
      mode = TRACE_ALL;
      for (int k = 0; k < 28; k++) send(32'h600 + 32'(4 * k));
      chk("t5_cnt4_sat", b_cnt, 4'd15);
      chk("t5_cnt16", a_cnt, 16'd20);
      chk("t5_ovf", b_ovf, 1'b1);
      clr = 1'b1;
      send(32'h700);
      clr = 1'b0;
      chk("t5_clr_cnt4", b_cnt, 4'd0);
      chk("t5_clr_cnt16", a_cnt, 16'd0);
      chk("t5_clr_ovf", b_ovf, 1'b0);
      rdy = 1'b1;
      send(32'h704);   // carries gap=1 via scoreboard
      idle(10);
      chk("t5_drained", a_level, 4'd0);

      // 6: reset with level 5, gap armed and counters non-zero
      rdy = 1'b0;
      for (int k = 0; k < 9; k++) send(32'h800 + 32'(4 * k));
      rdy = 1'b1;
      idle(3);
      rdy = 1'b0;
      chk("t6_level5", a_level, 4'd5);
      chk("t6_cnt_pre", a_cnt, 16'd1);
      rst = 1'b1;
      send(32'h900);
      rst = 1'b0;
      chk("t6_valid", a_valid, 1'b0);
      chk("t6_level", a_level, 4'd0);
      chk("t6_cnt", a_cnt, 16'd0);
      chk("t6_ovf", a_ovf, 1'b0);
      rdy = 1'b1;
      send(32'hA00);
      chk("t6_gap_after_rst", a_gap, 1'b0);
      idle(3);
      chk("end_level", a_level, 4'd0);
      chk("end_sbq", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
